// File: rtl/regfile_sequencer.sv
// Command sequencer for the 8-entry register file control port.
// Expands LDI / MOV / SWAP commands into single-action read and write cycles.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for a command; cmd_ready high
// S_READ  | rf_out_en high; rf_rdata captured into hold at cycle end
// S_WRITE | rf_write_en high; writes imm (LDI) or hold (MOV/SWAP)
// S_DONE  | one-cycle done pulse (with err for a rejected SWAP)
module regfile_sequencer #(
   parameter int N       = 8,
   parameter int SCRATCH = 7
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic [1:0]   cmd_op,
   input  logic [2:0]   cmd_dst,
   input  logic [2:0]   cmd_src,
   input  logic [N-1:0] cmd_imm,
   output logic         busy,
   output logic         done,
   output logic         err,
   output logic         rf_write_en,
   output logic         rf_out_en,
   output logic [2:0]   rf_sel_in,
   output logic [2:0]   rf_sel_out,
   output logic [N-1:0] rf_wdata,
   input  logic [N-1:0] rf_rdata
);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

   localparam logic [1:0] OP_NOP  = 2'd0;
   localparam logic [1:0] OP_LDI  = 2'd1;
   localparam logic [1:0] OP_MOV  = 2'd2;
   localparam logic [1:0] OP_SWAP = 2'd3;
   localparam logic [2:0] SCR     = 3'(SCRATCH);

   state_t       state, state_n;
   logic [1:0]   op_q, op_n;
   logic [1:0]   step, step_n;
   logic [2:0]   dst_q, dst_n;
   logic [2:0]   src_q, src_n;
   logic [N-1:0] imm_q, imm_n;
   logic [N-1:0] hold, hold_n;
   logic         err_q, err_n;
   logic         accept;
   logic [2:0]   sel_in_n, sel_out_n;
   logic [N-1:0] wdata_n;

   assign accept = cmd_valid && cmd_ready;

   always_comb begin
      state_n = state;
      op_n    = op_q;
      dst_n   = dst_q;
      src_n   = src_q;
      imm_n   = imm_q;
      step_n  = step;
      err_n   = err_q;
      hold_n  = (state == S_READ) ? rf_rdata : hold;
      case (state)
         S_IDLE: begin
            if (accept) begin
               op_n   = cmd_op;
               dst_n  = cmd_dst;
               src_n  = cmd_src;
               imm_n  = cmd_imm;
               step_n = 2'd0;
               err_n  = 1'b0;
               case (cmd_op)
                  OP_NOP: state_n = S_DONE;
                  OP_LDI: state_n = S_WRITE;
                  OP_MOV: state_n = S_READ;
                  default: begin
                     // SWAP touching the scratch register would destroy its own temporary
                     if (cmd_dst == SCR || cmd_src == SCR) begin
                        state_n = S_DONE;
                        err_n   = 1'b1;
                     end else begin
                        state_n = S_READ;
                     end
                  end
               endcase
            end
         end
         S_READ:  state_n = S_WRITE;
         S_WRITE: begin
            if (op_q == OP_SWAP && step != 2'd2) begin
               state_n = S_READ;
               step_n  = step + 2'd1;
            end else begin
               state_n = S_DONE;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   // Port values for the upcoming state, registered below so they line up with it.
   always_comb begin
      sel_out_n = 3'd0;
      sel_in_n  = 3'd0;
      wdata_n   = '0;
      if (state_n == S_READ) begin
         if (op_n == OP_MOV) begin
            sel_out_n = src_n;
         end else begin
            case (step_n)
               2'd0:    sel_out_n = dst_n;
               2'd1:    sel_out_n = src_n;
               default: sel_out_n = SCR;
            endcase
         end
      end
      if (state_n == S_WRITE) begin
         wdata_n = (op_n == OP_LDI) ? imm_n : hold_n;
         if (op_n == OP_LDI || op_n == OP_MOV) begin
            sel_in_n = dst_n;
         end else begin
            case (step_n)
               2'd0:    sel_in_n = SCR;
               2'd1:    sel_in_n = dst_n;
               default: sel_in_n = src_n;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         op_q        <= OP_NOP;
         dst_q       <= 3'd0;
         src_q       <= 3'd0;
         imm_q       <= '0;
         step        <= 2'd0;
         hold        <= '0;
         err_q       <= 1'b0;
         cmd_ready   <= 1'b1;
         busy        <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
         rf_write_en <= 1'b0;
         rf_out_en   <= 1'b0;
         rf_sel_in   <= 3'd0;
         rf_sel_out  <= 3'd0;
         rf_wdata    <= '0;
      end else begin
         state       <= state_n;
         op_q        <= op_n;
         dst_q       <= dst_n;
         src_q       <= src_n;
         imm_q       <= imm_n;
         step        <= step_n;
         hold        <= hold_n;
         err_q       <= err_n;
         cmd_ready   <= (state_n == S_IDLE);
         busy        <= (state_n != S_IDLE);
         done        <= (state_n == S_DONE);
         err         <= (state_n == S_DONE) && err_n;
         rf_write_en <= (state_n == S_WRITE);
         rf_out_en   <= (state_n == S_READ);
         rf_sel_in   <= sel_in_n;
         rf_sel_out  <= sel_out_n;
         rf_wdata    <= wdata_n;
      end
   end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Bench for regfile_sequencer: register-file model plus an architectural reference
// that predicts each command's writes, latency and final register contents.
module tb_regfile_sequencer;
   localparam int N = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         cmd_valid;
   logic         cmd_ready;
   logic [1:0]   cmd_op;
   logic [2:0]   cmd_dst;
   logic [2:0]   cmd_src;
   logic [N-1:0] cmd_imm;
   logic         busy, done, err;
   logic         rf_write_en, rf_out_en;
   logic [2:0]   rf_sel_in, rf_sel_out;
   logic [N-1:0] rf_wdata, rf_rdata;

   logic [7:0] rf_mem [8];
   logic [7:0] ref_rf [8];
   bit         known  [8];
   int         total = 0;
   int         bad   = 0;
   bit         mon_on = 1'b0;

   regfile_sequencer #(.N(N), .SCRATCH(7)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_dst(cmd_dst), .cmd_src(cmd_src), .cmd_imm(cmd_imm),
      .busy(busy), .done(done), .err(err),
      .rf_write_en(rf_write_en), .rf_out_en(rf_out_en),
      .rf_sel_in(rf_sel_in), .rf_sel_out(rf_sel_out),
      .rf_wdata(rf_wdata), .rf_rdata(rf_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (rf_write_en) rf_mem[rf_sel_in] <= rf_wdata;
   assign rf_rdata = rf_mem[rf_sel_out];

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (mon_on) begin
         check_val("enables_exclusive", 32'(rf_write_en && rf_out_en), 32'd0);
         if (!rf_write_en) begin
            check_val("idle_sel_in", 32'(rf_sel_in), 32'd0);
            check_val("idle_wdata", 32'(rf_wdata), 32'd0);
         end
         if (!rf_out_en) check_val("idle_sel_out", 32'(rf_sel_out), 32'd0);
         check_val("err_only_with_done", 32'(err && !done), 32'd0);
         check_val("ready_is_not_busy", 32'(cmd_ready), 32'(!busy));
      end
   end

   task automatic compare_rf(input string tag);
      for (int i = 0; i < 8; i++)
         if (known[i]) check_val(tag, 32'(rf_mem[i]), 32'(ref_rf[i]));
   endtask

   task automatic idle_wait();
      int g = 0;
      while (!cmd_ready && g < 20) begin
         @(negedge clk);
         g++;
      end
      check_val("accept_ready", 32'(cmd_ready), 32'd1);
   endtask

   task automatic run_cmd(input logic [1:0] op, input logic [2:0] d, input logic [2:0] s,
                          input logic [7:0] imm);
      int         lat;
      bit         e;
      logic [2:0] wi[$];
      logic [7:0] wd[$];
      int         wc[$];
      logic [2:0] oi[$];
      logic [7:0] od[$];
      int         oc[$];
      int         done_k;
      logic [7:0] a, b;
      e = 1'b0;
      case (op)
         2'd0: lat = 1;
         2'd1: begin lat = 2; wi.push_back(d); wd.push_back(imm); wc.push_back(1); end
         2'd2: begin lat = 3; wi.push_back(d); wd.push_back(ref_rf[s]); wc.push_back(2); end
         default: begin
            if (d == 3'd7 || s == 3'd7) begin
               lat = 1;
               e   = 1'b1;
            end else begin
               lat = 7;
               a = ref_rf[d];
               b = ref_rf[s];
               wi.push_back(3'd7); wd.push_back(a); wc.push_back(2);
               wi.push_back(d);    wd.push_back(b); wc.push_back(4);
               wi.push_back(s);    wd.push_back(a); wc.push_back(6);
            end
         end
      endcase
      for (int i = 0; i < wi.size(); i++) begin
         ref_rf[wi[i]] = wd[i];
         known[wi[i]]  = 1'b1;
      end

      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_dst   = d;
      cmd_src   = s;
      cmd_imm   = imm;
      idle_wait();
      done_k = 0;
      for (int k = 1; k <= 12 && done_k == 0; k++) begin
         @(negedge clk);
         if (k == 1) begin
            cmd_valid = 1'b0;
            cmd_op    = 2'($urandom_range(0, 3));
            cmd_dst   = 3'($urandom_range(0, 7));
            cmd_src   = 3'($urandom_range(0, 7));
            cmd_imm   = 8'($urandom_range(0, 255));
         end
         if (rf_write_en) begin
            oi.push_back(rf_sel_in);
            od.push_back(rf_wdata);
            oc.push_back(k);
         end
         if (done) begin
            done_k = k;
            check_val("err_flag", 32'(err), 32'(e));
         end else begin
            check_val("ready_low_busy", 32'(cmd_ready), 32'd0);
         end
      end
      check_val("latency", 32'(done_k), 32'(lat));
      check_val("write_count", 32'(oi.size()), 32'(wi.size()));
      for (int i = 0; i < wi.size() && i < oi.size(); i++) begin
         check_val("write_index", 32'(oi[i]), 32'(wi[i]));
         check_val("write_data", 32'(od[i]), 32'(wd[i]));
         check_val("write_cycle", 32'(oc[i]), 32'(wc[i]));
      end
      @(negedge clk);
      check_val("ready_after_done", 32'(cmd_ready), 32'd1);
      compare_rf("rf_contents");
   endtask

   initial begin
      logic [7:0] a, x;
      logic [1:0] op;
      logic [2:0] d, s;
      for (int i = 0; i < 8; i++) known[i] = 1'b0;
      rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_dst = 3'd0; cmd_src = 3'd0; cmd_imm = 8'd0;
      repeat (3) @(negedge clk);
      check_val("rst_ready", 32'(cmd_ready), 32'd1);
      check_val("rst_busy", 32'(busy), 32'd0);
      check_val("rst_done", 32'(done), 32'd0);
      check_val("rst_err", 32'(err), 32'd0);
      check_val("rst_we", 32'(rf_write_en), 32'd0);
      check_val("rst_oe", 32'(rf_out_en), 32'd0);
      check_val("rst_wdata", 32'(rf_wdata), 32'd0);
      rst = 1'b0;
      mon_on = 1'b1;

      for (int i = 0; i < 8; i++) run_cmd(2'd1, 3'(i), 3'd0, 8'($urandom_range(0, 255)));

      run_cmd(2'd1, 3'd3, 3'd0, 8'hA5);
      run_cmd(2'd1, 3'd2, 3'd0, 8'h3C);
      run_cmd(2'd2, 3'd5, 3'd2, 8'h00);
      run_cmd(2'd2, 3'd6, 3'd6, 8'h00);
      run_cmd(2'd1, 3'd0, 3'd0, 8'h11);
      run_cmd(2'd1, 3'd1, 3'd0, 8'h22);
      run_cmd(2'd3, 3'd0, 3'd1, 8'h00);
      run_cmd(2'd3, 3'd7, 3'd2, 8'h00);
      run_cmd(2'd3, 3'd4, 3'd4, 8'h00);
      run_cmd(2'd0, 3'd0, 3'd0, 8'h00);

      // valid held high: the queued MOV must wait for the LDI and see its result
      x = 8'($urandom_range(0, 255));
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = 2'd1; cmd_dst = 3'd3; cmd_src = 3'd0; cmd_imm = x;
      idle_wait();
      @(negedge clk);
      cmd_op = 2'd2; cmd_dst = 3'd4; cmd_src = 3'd3;
      check_val("b2b_ready_t1", 32'(cmd_ready), 32'd0);
      @(negedge clk);
      check_val("b2b_done_t2", 32'(done), 32'd1);
      check_val("b2b_ready_t2", 32'(cmd_ready), 32'd0);
      @(negedge clk);
      check_val("b2b_ready_t3", 32'(cmd_ready), 32'd1);
      @(negedge clk);
      cmd_valid = 1'b0;
      check_val("b2b_read_en", 32'(rf_out_en), 32'd1);
      check_val("b2b_read_sel", 32'(rf_sel_out), 32'd3);
      @(negedge clk);
      check_val("b2b_write_sel", 32'(rf_sel_in), 32'd4);
      check_val("b2b_write_data", 32'(rf_wdata), 32'(x));
      @(negedge clk);
      check_val("b2b_done", 32'(done), 32'd1);
      ref_rf[3] = x; ref_rf[4] = x;
      @(negedge clk);
      compare_rf("b2b_rf");

      // reset during SWAP step 1: scratch already written, rest abandoned
      a = ref_rf[0];
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = 2'd3; cmd_dst = 3'd0; cmd_src = 3'd1;
      idle_wait();
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      check_val("rst_swap_w0_en", 32'(rf_write_en), 32'd1);
      check_val("rst_swap_w0_data", 32'(rf_wdata), 32'(a));
      @(negedge clk);
      rst = 1'b1;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         check_val("rst_mid_ready", 32'(cmd_ready), 32'd1);
         check_val("rst_mid_busy", 32'(busy), 32'd0);
         check_val("rst_mid_done", 32'(done), 32'd0);
         check_val("rst_mid_we", 32'(rf_write_en), 32'd0);
         check_val("rst_mid_oe", 32'(rf_out_en), 32'd0);
      end
      rst = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         check_val("rst_after_done", 32'(done), 32'd0);
         check_val("rst_after_we", 32'(rf_write_en), 32'd0);
      end
      ref_rf[7] = a;
      compare_rf("rst_swap_rf");

      // reset during the WRITE cycle of an LDI: that write still lands
      x = 8'($urandom_range(0, 255));
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = 2'd1; cmd_dst = 3'd6; cmd_imm = x;
      idle_wait();
      @(negedge clk);
      cmd_valid = 1'b0;
      rst = 1'b1;
      check_val("rst_ldi_we", 32'(rf_write_en), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      check_val("rst_ldi_done", 32'(done), 32'd0);
      ref_rf[6] = x;
      @(negedge clk);
      compare_rf("rst_ldi_rf");

      for (int n = 0; n < 60; n++) begin
         op = 2'($urandom_range(0, 3));
         d  = 3'($urandom_range(0, 7));
         s  = 3'($urandom_range(0, 7));
         if (op == 2'd3 && $urandom_range(0, 3) != 0) begin
            d = 3'($urandom_range(0, 6));
            s = 3'($urandom_range(0, 6));
         end
         run_cmd(op, d, s, 8'($urandom_range(0, 255)));
      end

      mon_on = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
